// File: rtl/ahb_lite_timer_slave.sv
// AHB-Lite zero-wait timer: 32-bit down-counter with reload, one-shot mode and level IRQ.
// Define TIMER_PRESCALER_EN to add an 8-bit PRESC register at 0x10 and a tick prescaler.
module ahb_lite_timer_slave #(
   parameter int unsigned ADDR_W   = 12,
   parameter logic [31:0] LOAD_RST = 32'hFFFF_FFFF
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [3:0]  HPROT,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic        HREADYOUT,
   output logic [31:0] HRDATA,
   output logic        HRESP,
   output logic        TIMER_IRQ
);

   localparam int unsigned WW = ADDR_W - 2;
   localparam logic [WW-1:0] WCtrl   = WW'(0);
   localparam logic [WW-1:0] WLoad   = WW'(1);
   localparam logic [WW-1:0] WValue  = WW'(2);
   localparam logic [WW-1:0] WStatus = WW'(3);

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                         input logic [31:0] mask);
      return (old & ~mask) | (wdata & mask);
   endfunction

   logic unused_bits;
   assign unused_bits = ^{HPROT, HADDR[31:ADDR_W], HTRANS[0]};

   // Address phase capture
   logic          accept;
   logic [3:0]    strb;
   logic          valid_q, write_q;
   logic [WW-1:0] word_q;
   logic [3:0]    strb_q;

   assign accept = HSEL & HTRANS[1] & HREADY;

   always_comb begin
      strb = 4'b1111;
      case (HSIZE)
         3'd0:    strb = 4'b0001 << HADDR[1:0];
         3'd1:    strb = HADDR[1] ? 4'b1100 : 4'b0011;
         default: strb = 4'b1111;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         valid_q <= 1'b0;
         write_q <= 1'b0;
         word_q  <= '0;
         strb_q  <= '0;
      end else if (accept) begin
         valid_q <= 1'b1;
         write_q <= HWRITE;
         word_q  <= HADDR[ADDR_W-1:2];
         strb_q  <= strb;
      end else if (HREADY) begin
         valid_q <= 1'b0;
      end
   end

   // Data phase ends on the edge where HREADY is high; commit the write only then.
   logic        wr_en;
   logic [31:0] wmask;
   assign wr_en = valid_q & write_q & HREADY;
   assign wmask = {{8{strb_q[3]}}, {8{strb_q[2]}}, {8{strb_q[1]}}, {8{strb_q[0]}}};

   // Timer registers
   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] load_q, load_d;
   logic [31:0] value_q, value_d;
   logic        int_q, int_d;
   logic        tick;
   logic        int_set;

`ifdef TIMER_PRESCALER_EN
   localparam logic [WW-1:0] WPresc = WW'(4);
   logic [7:0] presc_q, presc_d;
   logic [7:0] pcnt_q, pcnt_d;
   logic       presc_wr;

   assign presc_wr = wr_en & (word_q == WPresc) & strb_q[0];
   assign tick     = ctrl_q[0] & (pcnt_q == presc_q);

   always_comb begin
      presc_d = presc_wr ? HWDATA[7:0] : presc_q;
      if (!ctrl_q[0] || presc_wr || tick) begin
         pcnt_d = 8'd0;
      end else begin
         pcnt_d = pcnt_q + 8'd1;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         presc_q <= 8'd0;
         pcnt_q  <= 8'd0;
      end else begin
         presc_q <= presc_d;
         pcnt_q  <= pcnt_d;
      end
   end
`else
   assign tick = ctrl_q[0];
`endif

   always_comb begin
      ctrl_d  = ctrl_q;
      load_d  = load_q;
      value_d = value_q;
      int_d   = int_q;
      int_set = 1'b0;
      if (tick) begin
         if (value_q != 32'd0) begin
            value_d = value_q - 32'd1;
         end else begin
            int_set = 1'b1;
            if (ctrl_q[2]) begin
               ctrl_d[0] = 1'b0;
            end else begin
               value_d = load_q;
            end
         end
      end
      // Bus writes are applied after the tick so they take priority over it.
      if (wr_en) begin
         case (word_q)
            WCtrl:   if (strb_q[0]) ctrl_d = HWDATA[2:0];
            WLoad:   load_d = merge(load_q, HWDATA, wmask);
            WValue:  value_d = merge(value_q, HWDATA, wmask);
            WStatus: if (strb_q[0] && HWDATA[0]) int_d = 1'b0;
            default: ;
         endcase
      end
      if (int_set) int_d = 1'b1;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ctrl_q  <= 3'd0;
         load_q  <= LOAD_RST;
         value_q <= 32'd0;
         int_q   <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         load_q  <= load_d;
         value_q <= value_d;
         int_q   <= int_d;
      end
   end

   // Read data mux
   always_comb begin
      HRDATA = 32'd0;
      if (valid_q && !write_q) begin
         case (word_q)
            WCtrl:   HRDATA = {29'd0, ctrl_q};
            WLoad:   HRDATA = load_q;
            WValue:  HRDATA = value_q;
            WStatus: HRDATA = {31'd0, int_q};
`ifdef TIMER_PRESCALER_EN
            WPresc:  HRDATA = {24'd0, presc_q};
`endif
            default: HRDATA = 32'd0;
         endcase
      end
   end

   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;
   assign TIMER_IRQ = int_q & ctrl_q[1];

endmodule

// File: tb/tb_ahb_lite_timer_slave.sv
// Randomised scoreboard bench for ahb_lite_timer_slave with a register-level reference model.
module tb_ahb_lite_timer_slave;

   logic        HCLK    = 1'b0;
   logic        HRESETn = 1'b0;
   logic        HSEL    = 1'b0;
   logic [31:0] HADDR   = 32'd0;
   logic [1:0]  HTRANS  = 2'd0;
   logic        HWRITE  = 1'b0;
   logic [2:0]  HSIZE   = 3'd0;
   logic [3:0]  HPROT   = 4'd0;
   logic        HREADY  = 1'b1;
   logic [31:0] HWDATA  = 32'd0;
   logic        HREADYOUT;
   logic [31:0] HRDATA;
   logic        HRESP;
   logic        TIMER_IRQ;

   ahb_lite_timer_slave dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HPROT     (HPROT),
      .HREADY    (HREADY),
      .HWDATA    (HWDATA),
      .HREADYOUT (HREADYOUT),
      .HRDATA    (HRDATA),
      .HRESP     (HRESP),
      .TIMER_IRQ (TIMER_IRQ)
   );

   always #5 HCLK = ~HCLK;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        irq;
   } exp_t;
   exp_t sb_q[$];
   bit   armed = 1'b0;

   // Reference model state: the register file as the programmer sees it.
   logic [2:0]  m_ctrl  = 3'd0;
   logic [31:0] m_load  = 32'hFFFF_FFFF;
   logic [31:0] m_value = 32'd0;
   logic        m_int   = 1'b0;
   logic [7:0]  m_presc = 8'd0;
   int          m_pcnt  = 0;
   logic        dp_valid = 1'b0;
   logic        dp_write = 1'b0;
   logic [11:0] dp_off   = 12'd0;
   logic [3:0]  dp_mask  = 4'd0;

   function automatic logic [3:0] lanes(input logic [2:0] size, input logic [1:0] a);
      int n, first;
      logic [3:0] m;
      n = (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
      first = (int'(a) / n) * n;
      m = 4'd0;
      for (int b = 0; b < 4; b++) if (b >= first && b < first + n) m[b] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] bytes_in(input logic [31:0] old, input logic [31:0] d,
                                            input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_read(input logic [11:0] off);
      case (off)
         12'h000: return {29'd0, m_ctrl};
         12'h004: return m_load;
         12'h008: return m_value;
         12'h00C: return {31'd0, m_int};
`ifdef TIMER_PRESCALER_EN
         12'h010: return {24'd0, m_presc};
`endif
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge HCLK) begin
      exp_t        e;
      logic        wr, tick, set, presc_wr;
      logic [2:0]  n_ctrl;
      logic [31:0] n_load, n_value;
      logic        n_int;
      if (!HRESETn) begin
         e.rdata = 32'd0;
         e.irq   = 1'b0;
         if (armed) sb_q.push_back(e);
         m_ctrl = 3'd0; m_load = 32'hFFFF_FFFF; m_value = 32'd0; m_int = 1'b0;
         m_presc = 8'd0; m_pcnt = 0; dp_valid = 1'b0;
      end else begin
         e.rdata = (dp_valid && !dp_write) ? model_read(dp_off) : 32'd0;
         e.irq   = m_int && m_ctrl[1];
         if (armed) sb_q.push_back(e);

         wr = dp_valid && dp_write && HREADY;
`ifdef TIMER_PRESCALER_EN
         tick = m_ctrl[0] && (m_pcnt == int'(m_presc));
`else
         tick = m_ctrl[0];
`endif
         n_ctrl = m_ctrl; n_load = m_load; n_value = m_value; n_int = m_int;
         set = 1'b0; presc_wr = 1'b0;
         if (tick) begin
            if (m_value > 0) n_value = m_value - 1;
            else begin
               set = 1'b1;
               n_int = 1'b1;
               if (m_ctrl[2]) n_ctrl[0] = 1'b0;
               else n_value = m_load;
            end
         end
         if (wr) begin
            case (dp_off)
               12'h000: if (dp_mask[0]) n_ctrl = HWDATA[2:0];
               12'h004: n_load = bytes_in(m_load, HWDATA, dp_mask);
               12'h008: n_value = bytes_in(m_value, HWDATA, dp_mask);
               12'h00C: if (dp_mask[0] && HWDATA[0] && !set) n_int = 1'b0;
`ifdef TIMER_PRESCALER_EN
               12'h010: if (dp_mask[0]) begin m_presc = HWDATA[7:0]; presc_wr = 1'b1; end
`endif
               default: ;
            endcase
         end
         if (!m_ctrl[0] || presc_wr || tick) m_pcnt = 0;
         else m_pcnt = m_pcnt + 1;
         m_ctrl = n_ctrl; m_load = n_load; m_value = n_value; m_int = n_int;

         if (HSEL && HTRANS[1] && HREADY) begin
            dp_valid = 1'b1;
            dp_write = HWRITE;
            dp_off   = HADDR[11:0] & 12'hFFC;
            dp_mask  = lanes(HSIZE, HADDR[1:0]);
         end else if (HREADY) begin
            dp_valid = 1'b0;
         end
      end
   end

   // Monitor: latch outputs mid-cycle, compare against the model entry for that cycle.
   initial begin
      logic [31:0] a_rdata;
      logic        a_irq, a_rdy, a_resp;
      exp_t        e;
      @(negedge HCLK);
      forever begin
         #3;
         a_rdata = HRDATA; a_irq = TIMER_IRQ; a_rdy = HREADYOUT; a_resp = HRESP;
         armed = 1'b1;
         @(posedge HCLK);
         #1;
         n_checks++;
         if (sb_q.size() == 0) begin
            $display("FAIL sb_empty at %0t: no expected entry for rdata=%h", $time, a_rdata);
         end else begin
            e = sb_q.pop_front();
            if (a_rdata !== e.rdata || a_irq !== e.irq || a_rdy !== 1'b1 || a_resp !== 1'b0)
               $display("FAIL bus_out at %0t: got rdata=%h irq=%b rdy=%b resp=%b, want rdata=%h irq=%b rdy=1 resp=0",
                        $time, a_rdata, a_irq, a_rdy, a_resp, e.rdata, e.irq);
            else n_pass++;
         end
         @(negedge HCLK);
      end
   end

   // Driver: one call = one cycle, starting at a falling edge.
   logic [31:0] dp_wdata = 32'd0;

   task automatic bus(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wd,
                      input logic rdy);
      HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr;
      HREADY = rdy; HWDATA = dp_wdata; HPROT = 4'($urandom);
      @(negedge HCLK);
      if (sel && trans[1] && rdy) dp_wdata = wd;
      else if (rdy) dp_wdata = $urandom;
   endtask

   task automatic wr32(input logic [31:0] addr, input logic [31:0] d);
      bus(1'b1, 2'b10, 1'b1, 3'd2, addr, d, 1'b1);
   endtask

   task automatic rd32(input logic [31:0] addr);
      bus(1'b1, 2'b10, 1'b0, 3'd2, addr, $urandom, 1'b1);
   endtask

   task automatic idle();
      bus(1'b0, 2'b00, 1'b0, 3'd0, $urandom, $urandom, 1'b1);
   endtask

   initial begin
      @(negedge HCLK);
      idle(); idle();
      HRESETn = 1'b1;
      idle();
      rd32(32'h4); idle();

      // Periodic count with LOAD=3
      wr32(32'h4, 32'd3); wr32(32'h8, 32'd3); wr32(32'h0, 32'd3);
      repeat (6) rd32(32'h8);
      rd32(32'hC); wr32(32'hC, 32'd1); rd32(32'hC); idle();

      // One-shot without IRQ_EN
      wr32(32'h0, 32'd0); wr32(32'h8, 32'd2); wr32(32'h0, 32'd5);
      repeat (4) rd32(32'h8);
      rd32(32'h0); rd32(32'hC); idle();

      // Sub-word writes onto LOAD
      wr32(32'h4, 32'd0);
      bus(1'b1, 2'b10, 1'b1, 3'd0, 32'h5, 32'h0000_AB00, 1'b1);
      bus(1'b1, 2'b10, 1'b1, 3'd1, 32'h6, 32'h1234_0000, 1'b1);
      rd32(32'h4); idle();

      // Write stretched by HREADY=0, then read back; idle transfer writes nothing
      wr32(32'h8, 32'd10);
      bus(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
      rd32(32'h8);
      bus(1'b1, 2'b00, 1'b1, 3'd2, 32'h8, 32'h55, 1'b1);
      idle(); rd32(32'h8); idle();

      // INT set collides with STATUS clear (LOAD=0 periodic sets INT every tick)
      wr32(32'h4, 32'd0); wr32(32'h8, 32'd0); wr32(32'h0, 32'd3);
      repeat (3) wr32(32'hC, 32'd1);
      rd32(32'hC); idle();

`ifdef TIMER_PRESCALER_EN
      wr32(32'h0, 32'd0); wr32(32'h10, 32'd2); wr32(32'h8, 32'd9); wr32(32'h0, 32'd1);
      repeat (10) rd32(32'h8);
      rd32(32'h10); wr32(32'h10, 32'd0); idle();
`endif

      // Reset during a write data phase
      wr32(32'h4, 32'h1111_1111);
      HRESETn = 1'b0;
      idle(); idle();
      HRESETn = 1'b1;
      rd32(32'h4); idle();

      for (int i = 0; i < 1500; i++) begin
         logic [31:0] a, d;
         logic [2:0]  sz;
         case ($urandom_range(0, 7))
            0: a = 32'h000;
            1: a = 32'h004;
            2: a = 32'h008;
            3: a = 32'h00C;
            4: a = 32'h010;
            5: a = 32'h014;
            6: a = 32'h100;
            default: a = 32'hFFC;
         endcase
         sz = 3'($urandom_range(0, 2));
         if (sz == 3'd0) a[1:0] = 2'($urandom);
         else if (sz == 3'd1) a[1:0] = {1'($urandom), 1'b0};
         a[31:12] = 20'($urandom);
         d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 5));
         bus(1'($urandom_range(0, 9) != 0), 2'($urandom), 1'($urandom), sz, a, d,
             1'($urandom_range(0, 6) != 0));
      end

      repeat (3) idle();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ahb_lite_timer_slave.md
Name: ahb_lite_timer_slave

Overview:
- AHB-Lite subordinate (responder) timer peripheral at the far end of the bus matrix TIMER output stage.
- Accepts register read/write transfers and implements a 32-bit down-counter with reload, one-shot mode and a level interrupt.
- Zero-wait-state, always-OKAY responder; drives HREADYOUT back into the output stage's HREADY return path.

Parameters:
- ADDR_W, 12, number of HADDR LSBs decoded as register offset; upper bits ignored (decode done by matrix).
- LOAD_RST, 32'hFFFF_FFFF, reset value of the LOAD register.

Ports:
- HCLK  input  1  bus clock
- HRESETn  input  1  asynchronous active-low reset
- HSEL  input  1  subordinate select from output stage
- HADDR  input  32  address
- HTRANS  input  2  transfer type; only NONSEQ/SEQ (HTRANS[1]=1) are acted on
- HWRITE  input  1  1=write
- HSIZE  input  3  transfer size (byte/half/word)
- HPROT  input  4  protection; ignored
- HREADY  input  1  bus ready (previous transfer complete)
- HWDATA  input  32  write data (data phase)
- HREADYOUT  output  1  subordinate ready; constant 1
- HRDATA  output  32  read data (data phase)
- HRESP  output  1  response; constant 0 (OKAY)
- TIMER_IRQ  output  1  level interrupt

Behaviour:
- Reset (async, HRESETn=0): CTRL=0, LOAD=LOAD_RST, VALUE=0, STATUS=0, all address-phase registers cleared; HRDATA=0, TIMER_IRQ=0, HREADYOUT=1, HRESP=0. Reset mid-transfer aborts it; no register is updated.
- Register map (offset HADDR[ADDR_W-1:0]):
  - 0x00 CTRL: bit0 EN, bit1 IRQ_EN, bit2 ONESHOT; bits[31:3] read 0.
  - 0x04 LOAD.
  - 0x08 VALUE (current count).
  - 0x0C STATUS: bit0 INT; read returns INT; writing 1 to bit0 clears INT.
  - Other offsets read 0; writes ignored; response still OKAY.
- Address phase: transfer accepted when HSEL & HTRANS[1] & HREADY. On acceptance, register offset, HWRITE and byte strobes are captured.
  - Byte strobes decoded from HSIZE and HADDR[1:0], little-endian: byte -> 1 lane, half -> 2 lanes by HADDR[1], word -> all 4 lanes.
  - When not accepted and HREADY=1, the captured valid flag clears. HREADY=0 holds the capture.
- Data phase write: in the cycle after acceptance, strobed lanes of HWDATA are written at the HCLK edge ending the data phase. Read-back visible one cycle after that.
- Data phase read: HRDATA is a combinational mux of the captured offset over current register values; 0 when no valid read is in data phase. Latency: data in the cycle after the address phase.
- Counter: tick = EN (see Optional Feature). On each tick:
  - VALUE!=0: VALUE decrements by 1.
  - VALUE==0: INT is set. If ONESHOT=0, VALUE reloads from LOAD. If ONESHOT=1, VALUE stays 0 and EN clears.
  - EN=0: VALUE holds.
- Priority and boundary cases:
  - A bus write to VALUE beats a tick in the same cycle.
  - A bus write to CTRL beats the one-shot EN clear.
  - Writing LOAD does not change VALUE.
  - INT set and a STATUS clear in the same cycle: set wins (INT=1).
  - LOAD=0 in periodic mode: INT sets every tick.
  - Wrap: VALUE never underflows below 0.
- TIMER_IRQ = INT & IRQ_EN, registered-free (combinational from flops).

Optional Feature:
- Macro TIMER_PRESCALER_EN.
- Defined:
  - Adds an 8-bit PRESC register at 0x10 (reset 0) and an 8-bit prescale counter.
  - tick asserts when EN=1 and the prescale counter equals PRESC; the counter then returns to 0, otherwise it increments while EN=1.
  - The counter is cleared when EN=0 or when PRESC is written.
- Not defined: tick = EN every HCLK; 0x10 is unmapped (reads 0).

Test Plan:
- Reset release -> HRDATA=0, HREADYOUT=1, HRESP=0, TIMER_IRQ=0; read 0x04 returns 32'hFFFF_FFFF.
- Write LOAD=3, VALUE=3, CTRL=3 (EN, IRQ_EN, periodic) -> VALUE reads 3,2,1,0,3 on successive cycles; INT/TIMER_IRQ rise the cycle after VALUE=0 tick; write 1 to 0x0C -> TIMER_IRQ=0.
- CTRL=5 (EN, ONESHOT), VALUE=2 -> VALUE reaches 0, EN reads 0, INT=1, TIMER_IRQ=0 (IRQ_EN=0).
- Byte write 8'hAB at 0x05 (HSIZE=0) onto LOAD=0 -> LOAD reads 32'h0000_AB00; halfword 16'h1234 at 0x06 -> 32'h1234_AB00.
- Back-to-back write VALUE=10 then read VALUE, with HREADY=0 for one cycle between -> read returns 10 (or 9 if EN=1 and a tick occurred), no lost or duplicated write; an idle transfer (HTRANS=0) to 0x08 writes nothing.
- Simultaneous INT set and STATUS clear -> INT=1; with TIMER_PRESCALER_EN and PRESC=2, VALUE decrements every 3 cycles.
